ddr_rx_deserializer: RTL and testbench
======================================

// Module: ddr_rx_deserializer
// PURPOSE
//  Input-side counterpart of the O_DDR/O_BUFT_DS transmit path: fabric logic behind an I_DDR capture.
//  Takes the 2-bit per-clock DDR sample pair and hunts for a sync word at either bit phase.
//  Once locked, deserializes the stream into WORD_W-bit words and buffers them in a small FIFO.
//  The FIFO drains through a valid/ready interface.
// PARAMETERS
//  WORD_W      8      word width in bits; even, >= 4
//  FIFO_DEPTH  4      word FIFO depth; power of 2, >= 2
//  SYNC_WORD   8'hA5  alignment pattern, WORD_W bits, MSB received first
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous reset, active-low
//  en          in   1       capture enable (I_DDR E); low = ignore ddr_d, hold all state
//  ddr_d       in   2       [0] rising-edge sample (earlier bit), [1] falling-edge sample
//  realign     in   1       sync pulse: return to HUNT, flush FIFO, clear overflow
//  word_data   out  WORD_W  FIFO head word; 0 when FIFO empty
//  word_valid  out  1       FIFO not empty
//  word_ready  in   1       consumer accepts head word when word_valid & word_ready
//  locked      out  1       high in LOCKED state
//  overflow    out  1       sticky: a completed word was dropped because FIFO was full
// BEHAVIOUR
//  Reset (rst=0, async): state=HUNT, shift window=0, beat count=0, FIFO empty.
//   Outputs after reset: word_data=0, word_valid=0, locked=0, overflow=0.
//  Shift window sr[WORD_W:0]: on each en=1 cycle, sr <= {sr[WORD_W-2:0], ddr_d[0], ddr_d[1]}; 2 bits/cycle.
//  Phase slices: EVEN = sr[WORD_W-1:0]; ODD = sr[WORD_W:1]. Both are evaluated on the updated window.
//  HUNT state:
//   - If EVEN == SYNC_WORD -> LOCKED, phase=EVEN; else if ODD == SYNC_WORD -> LOCKED, phase=ODD.
//   - EVEN wins when both match. The beat counter clears to 0.
//   - The sync word itself is never written to the FIFO.
//  LOCKED state:
//   - Beat counter increments on en=1 cycles and wraps at WORD_W/2.
//   - On wrap, the slice selected by phase is the completed word and is pushed to the FIFO.
//   - The first data word completes exactly WORD_W/2 enabled cycles after the sync match.
//   - No sync recheck; LOCKED exits only via realign or rst.
//  Latency: the pair completing a word is sampled at edge k; word_valid and word_data update after edge k+1.
//  FIFO is first-word-fall-through with registered pointers and a count 0..FIFO_DEPTH.
//   - Pop when word_valid & word_ready.
//   - Push while full with a simultaneous pop: push accepted, count unchanged, no overflow.
//   - Push while full without a pop: word dropped, overflow <= 1 (sticky).
//   - Pointers wrap modulo FIFO_DEPTH.
//  realign=1 (sync) that cycle: state=HUNT, beat count=0, FIFO flushed, overflow=0.
//   - Window sr keeps shifting, so a sync word straddling realign can still match next cycle.
//   - realign has priority over any push/pop in the same cycle.
//  en=0: no shift, no count, no push; pops via word_ready still proceed.
//  Reset mid-word or mid-hunt: all of the above return to reset values immediately.
// CONFIGURATION
//  DDR_RX_SYNC_STRIP_EN defined:
//   - In LOCKED, a completed word equal to SYNC_WORD is idle fill: discarded, never pushed, never counts as overflow.
//  DDR_RX_SYNC_STRIP_EN undefined: every completed word is pushed, including SYNC_WORD values.
// TESTING
//  (defaults; pair = {ddr_d[0],ddr_d[1]})
//  1 Reset/idle:
//    rst=0 then 1, en=1, ddr_d=0 for 20 cycles -> locked=0, word_valid=0, word_data=0, overflow=0.
//  2 Even lock:
//    pairs 10,10,01,01 (A5) then 00,11,11,00 (3C) -> locked=1 after the 4th pair.
//    word_valid=1, word_data=8'h3C two edges after the 8th pair.
//  3 Odd lock:
//    one leading pair 00, then bit stream 1 followed by A5 followed by 3C, 2 bits/cycle -> phase=ODD, word_data=8'h3C.
//  4 Overflow:
//    locked, word_ready=0, push 5 words 01..05 -> FIFO holds 01..04, overflow=1.
//    Then realign=1 -> FIFO empty, overflow=0, locked=0.
//  5 Full + pop:
//    FIFO full, word_ready=1 on the cycle word 05 completes -> 01 popped, 05 stored, overflow stays 0.
//  6 Strip:
//    with DDR_RX_SYNC_STRIP_EN, words A5,3C,A5,77 after lock -> only 3C,77 appear.
//    Without it, all four appear.
//    en=0 gaps mid-word delay the output but do not corrupt it.

Source files
------------

// File: rtl/ddr_rx_deserializer.sv
// ddr_rx_deserializer
//   Fabric logic behind an I_DDR capture. Shifts in the two DDR samples per
//   clock and hunts for SYNC_WORD at either bit phase. Once locked, it cuts
//   the stream into WORD_W-bit words and queues them in a small
//   first-word-fall-through FIFO that drains over valid/ready.
//   Optional build macro: DDR_RX_SYNC_STRIP_EN. When it is defined, completed
//   words equal to SYNC_WORD are treated as idle fill and discarded.
module ddr_rx_deserializer #(
    parameter int                WORD_W     = 8,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [WORD_W-1:0] SYNC_WORD  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        ddr_d,
    input  logic              realign,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              locked,
    output logic              overflow
);

    localparam int HALF   = WORD_W / 2;
    localparam int BEAT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]        state;
    logic              phase;          // 0 = EVEN slice, 1 = ODD slice
    logic [BEAT_W-1:0] beat;
    logic [WORD_W:0]   sr;
    logic [WORD_W:0]   sr_next;
    logic [WORD_W-1:0] slice_even;
    logic [WORD_W-1:0] slice_odd;
    logic [WORD_W-1:0] word_cur;
    logic              beat_wrap;
    logic              keep_word;
    logic              word_done;

    // completed word waiting one cycle before it enters the FIFO
    logic              vld_p0;
    logic [WORD_W-1:0] data_p0;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              fifo_full;
    logic              fifo_pop;
    logic              fifo_wr;

    // Window update, phase slices and word-completion decode
    always_comb begin
        sr_next    = en ? {sr[WORD_W-2:0], ddr_d[0], ddr_d[1]} : sr;
        slice_even = sr_next[WORD_W-1:0];
        slice_odd  = sr_next[WORD_W:1];
        word_cur   = phase ? slice_odd : slice_even;
        beat_wrap  = en && (state == ST_LOCKED) && (beat == BEAT_LAST);
`ifdef DDR_RX_SYNC_STRIP_EN
        keep_word  = (word_cur != SYNC_WORD);
`else
        keep_word  = 1'b1;
`endif
        word_done  = beat_wrap && keep_word && !realign;
        fifo_full  = (cnt == CNT_FULL);
        fifo_pop   = word_valid && word_ready;
        // realign wins over the pending push; a full FIFO only accepts when it also pops
        fifo_wr    = vld_p0 && !realign && (!fifo_full || fifo_pop);
    end

    assign word_valid = (cnt != '0);
    assign word_data  = word_valid ? mem[rd_ptr] : '0;
    assign locked     = (state == ST_LOCKED);

    // Shift window, hunt/lock state machine and beat counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr     <= '0;
            state  <= ST_HUNT;
            phase  <= 1'b0;
            beat   <= '0;
            vld_p0 <= 1'b0;
        end else begin
            sr     <= sr_next;
            vld_p0 <= word_done;
            if (realign) begin
                state <= ST_HUNT;
                beat  <= '0;
            end else if (state == ST_HUNT) begin
                if (en && (slice_even == SYNC_WORD)) begin
                    state <= ST_LOCKED;
                    phase <= 1'b0;
                    beat  <= '0;
                end else if (en && (slice_odd == SYNC_WORD)) begin
                    state <= ST_LOCKED;
                    phase <= 1'b1;
                    beat  <= '0;
                end
            end else if (en) begin
                beat <= (beat == BEAT_LAST) ? '0 : beat + 1'b1;
            end
        end
    end

    // Capture the completed word for the FIFO write one cycle later
    always_ff @(posedge clk) begin
        data_p0 <= word_cur;
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= data_p0;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (realign) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (vld_p0 && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            if (fifo_wr && !fifo_pop) begin
                cnt <= cnt + 1'b1;
            end else if (!fifo_wr && fifo_pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_rx_deserializer.sv
// Testbench for ddr_rx_deserializer (default parameters). Honors
// DDR_RX_SYNC_STRIP_EN the same way the design does.
module tb_ddr_rx_deserializer;

    localparam int         W    = 8;
    localparam int         D    = 4;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] ddr_d;
    logic       realign;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready;
    logic       locked;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // reference model: bit window as an integer, word queue, pending word
    logic        m_locked;
    logic        m_phase;
    logic        m_ovf;
    logic        m_pend;
    logic [7:0]  m_pendw;
    int          m_nen;
    int unsigned m_win;
    logic [7:0]  mq[$];
    logic [7:0]  popped[$];

    always #5 clk = ~clk;

    ddr_rx_deserializer #(.WORD_W(W), .FIFO_DEPTH(D), .SYNC_WORD(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ddr_d      (ddr_d),
        .realign    (realign),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .locked     (locked),
        .overflow   (overflow)
    );

    function automatic logic [7:0] m_data();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    function automatic logic m_valid();
        return mq.size() != 0;
    endfunction

    function void model_reset();
        m_locked = 1'b0; m_phase = 1'b0; m_ovf = 1'b0; m_pend = 1'b0;
        m_pendw = 8'h00; m_nen = 0; m_win = 0;
        mq.delete();
    endfunction

    // one clock edge of the specified behaviour, given the inputs applied at it
    function void model_edge(input logic e, input logic [1:0] d, input logic ra, input logic rdy);
        logic       pop;
        logic       full;
        logic       np;
        logic [7:0] w;
        pop  = (mq.size() != 0) && rdy;
        full = (mq.size() == D);
        np   = 1'b0;
        if (ra) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_pend) begin
                if (!full || pop) mq.push_back(m_pendw);
                else m_ovf = 1'b1;
            end
        end
        if (e) m_win = ((m_win << 2) | (32'(d[0]) << 1) | 32'(d[1])) & 32'h1FF;
        if (ra) begin
            m_locked = 1'b0;
        end else if (!m_locked) begin
            if (e && (8'(m_win & 32'hFF) == SYNC)) begin
                m_locked = 1'b1; m_phase = 1'b0; m_nen = 0;
            end else if (e && (8'((m_win >> 1) & 32'hFF) == SYNC)) begin
                m_locked = 1'b1; m_phase = 1'b1; m_nen = 0;
            end
        end else if (e) begin
            m_nen++;
            if (m_nen % (W / 2) == 0) begin
                w = m_phase ? 8'((m_win >> 1) & 32'hFF) : 8'(m_win & 32'hFF);
`ifdef DDR_RX_SYNC_STRIP_EN
                if (w != SYNC) begin np = 1'b1; m_pendw = w; end
`else
                np = 1'b1; m_pendw = w;
`endif
            end
        end
        m_pend = np;
    endfunction

    task automatic step(input logic e, input logic [1:0] d, input logic ra, input logic rdy);
        en = e; ddr_d = d; realign = ra; word_ready = rdy;
        if (word_valid && word_ready && !realign) popped.push_back(word_data);
        @(posedge clk);
        model_edge(e, d, ra, rdy);
        #1;
    endtask

    task automatic send_word(input logic [7:0] b, input int gap_pct, input logic rdy);
        for (int i = 0; i < W / 2; i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++)
                step(1'b0, 2'($urandom), 1'b0, rdy);
            step(1'b1, {b[6-2*i], b[7-2*i]}, 1'b0, rdy);
        end
    endtask

    task automatic do_reset();
        en = 1'b0; ddr_d = 2'b00; realign = 1'b0; word_ready = 1'b0;
        rst = 1'b0;
        model_reset();
        popped.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b1; ddr_d = 2'b00; realign = 1'b0; word_ready = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({locked, word_valid, word_data, overflow} !== 11'b0) begin
            failures++;
            $display("FAIL reset_hold: got locked=%b valid=%b data=%h ovf=%b want all 0",
                     locked, word_valid, word_data, overflow);
        end
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 2'b00, 1'b0, 1'b0);
            checks++;
            if ({locked, word_valid, word_data, overflow} !== 11'b0) begin
                failures++;
                $display("FAIL reset_idle c%0d: got locked=%b valid=%b data=%h ovf=%b want all 0",
                         c, locked, word_valid, word_data, overflow);
            end
        end
    endtask

    task automatic test_even_lock();
        do_reset();
        send_word(8'hA5, 0, 1'b0);
        checks++;
        if (locked !== 1'b1 || word_valid !== 1'b0) begin
            failures++;
            $display("FAIL even_lock: got locked=%b valid=%b want 1 0", locked, word_valid);
        end
        send_word(8'h3C, 0, 1'b0);
        checks++;
        if (word_valid !== 1'b0) begin
            failures++;
            $display("FAIL even_latency: got valid=%b one edge after word, want 0", word_valid);
        end
        step(1'b0, 2'b00, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'h3C || overflow !== 1'b0) begin
            failures++;
            $display("FAIL even_word: got valid=%b data=%h ovf=%b want 1 3c 0",
                     word_valid, word_data, overflow);
        end
    endtask

    task automatic test_odd_lock();
        logic [17:0] s;
        s = {1'b1, 8'hA5, 8'h3C, 1'b0};
        do_reset();
        step(1'b1, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, {s[16-2*i], s[17-2*i]}, 1'b0, 1'b0);
            if (i == 3 || i == 4) begin
                checks++;
                if (locked !== (i == 4)) begin
                    failures++;
                    $display("FAIL odd_lock pair%0d: got locked=%b want %b", i, locked, i == 4);
                end
            end
        end
        step(1'b0, 2'b00, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'h3C) begin
            failures++;
            $display("FAIL odd_word: got valid=%b data=%h want 1 3c", word_valid, word_data);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_word(8'hA5, 0, 1'b0);
        for (int v = 1; v <= 5; v++) send_word(8'(v), 0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'h01 || overflow !== 1'b1 || mq.size() != D) begin
            failures++;
            $display("FAIL overflow_set: got valid=%b data=%h ovf=%b want 1 01 1",
                     word_valid, word_data, overflow);
        end
        step(1'b0, 2'b00, 1'b1, 1'b0);
        checks++;
        if ({locked, word_valid, word_data, overflow} !== 11'b0) begin
            failures++;
            $display("FAIL overflow_realign: got locked=%b valid=%b data=%h ovf=%b want all 0",
                     locked, word_valid, word_data, overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_q[$];
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05};
        do_reset();
        send_word(8'hA5, 0, 1'b0);
        for (int v = 1; v <= 4; v++) send_word(8'(v), 0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        send_word(8'h05, 0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || word_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_ovf: got ovf=%b valid=%b want 0 1", overflow, word_valid);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (word_valid !== 1'b1 || word_data !== exp_q[i]) begin
                failures++;
                $display("FAIL full_pop_drain%0d: got valid=%b data=%h want 1 %h",
                         i, word_valid, word_data, exp_q[i]);
            end
            step(1'b0, 2'b00, 1'b0, 1'b1);
        end
        checks++;
        if (word_valid !== 1'b0 || word_data !== 8'h00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_empty: got valid=%b data=%h ovf=%b want 0 00 0",
                     word_valid, word_data, overflow);
        end
    endtask

    task automatic test_strip();
        logic [7:0] exp_q[$];
        logic [7:0] words[4];
        words = '{8'hA5, 8'h3C, 8'hA5, 8'h77};
`ifdef DDR_RX_SYNC_STRIP_EN
        exp_q = '{8'h3C, 8'h77};
`else
        exp_q = '{8'hA5, 8'h3C, 8'hA5, 8'h77};
`endif
        do_reset();
        send_word(8'hA5, 0, 1'b1);
        popped.delete();
        for (int i = 0; i < 4; i++) send_word(words[i], 40, 1'b1);
        repeat (3) step(1'b0, 2'b00, 1'b0, 1'b1);
        checks++;
        if (popped.size() != exp_q.size()) begin
            failures++;
            $display("FAIL strip_count: got %0d words want %0d", popped.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (popped[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL strip_word%0d: got %h want %h", i, popped[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c % 150 == 10)
                send_word(SYNC, 20, 1'($urandom));
            else
                step(($urandom_range(9) < 8), 2'($urandom), ($urandom_range(249) == 0),
                     1'($urandom));
            checks++;
            if (locked !== m_locked || word_valid !== m_valid() ||
                word_data !== m_data() || overflow !== m_ovf) begin
                failures++;
                $display("FAIL random c%0d: got locked=%b valid=%b data=%h ovf=%b want %b %b %h %b",
                         c, locked, word_valid, word_data, overflow,
                         m_locked, m_valid(), m_data(), m_ovf);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h11, 0, 1'b0);
        send_word(8'h22, 0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({locked, word_valid, word_data, overflow} !== 11'b0) begin
            failures++;
            $display("FAIL reset_mid: got locked=%b valid=%b data=%h ovf=%b want all 0",
                     locked, word_valid, word_data, overflow);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h33, 0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'h33 || locked !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_relock: got valid=%b data=%h locked=%b want 1 33 1",
                     word_valid, word_data, locked);
        end
    endtask

    initial begin
        en = 1'b0; ddr_d = 2'b00; realign = 1'b0; word_ready = 1'b0; rst = 1'b0;
        test_reset();
        test_even_lock();
        test_odd_lock();
        test_overflow();
        test_full_pop();
        test_strip();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
